// File: rtl/hazard_filter_if.sv
// hazard_filter_if: bundles the per-channel data/enable inputs, the global
// controls and the filtered results of hazard_filter into one port.
interface hazard_filter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned GCNT_W = 8
);
  logic [NUM_CH-1:0] din;
  logic [NUM_CH-1:0] en;
  logic [1:0]        mode;
  logic              glitch_clr;
  logic [NUM_CH-1:0] flag;
  logic              flag_any;
  logic [GCNT_W-1:0] glitch_cnt;

  // Environment side: drives raw data and controls, observes results.
  modport master (
    output din, en, mode, glitch_clr,
    input  flag, flag_any, glitch_cnt
  );

  // Filter side.
  modport slave (
    input  din, en, mode, glitch_clr,
    output flag, flag_any, glitch_cnt
  );
endinterface

// File: rtl/hazard_filter.sv
// hazard_filter: per-channel synchroniser + stability filter.
// Each raw din bit is synchronised, gated by its enable and only accepted
// once the new value has held for STABLE_CYC consecutive cycles. Changes
// that revert early are discarded and counted as glitches (saturating,
// all channels combined). Results are presented as levels or as
// single-cycle edge pulses depending on the global mode.
module hazard_filter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SYNC_STG   = 2,
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned GCNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_filter_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
  localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
  localparam int unsigned SUM_W = ((GCNT_W > PC_W) ? GCNT_W : PC_W) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [SUM_W-1:0] GSAT     = SUM_W'({GCNT_W{1'b1}});

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_ANY   = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(bus.mode);

  // Synchroniser chains: index [SYNC_STG-1] is the settled output stage.
  logic [NUM_CH-1:0][SYNC_STG-1:0] sync_q;
  logic [NUM_CH-1:0]               sync_out;

  // Filter state.
  logic [NUM_CH-1:0]            f_q, f_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            cond;
  logic [NUM_CH-1:0]            accept;
  logic [NUM_CH-1:0]            glitch;

  // Output state.
  logic [NUM_CH-1:0] flag_q, flag_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [PC_W-1:0]   glitch_num;
  logic [SUM_W-1:0]  gsum;

  // Shift each raw data bit through its synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STG-2:0], bus.din[i]};
      end
    end
  end

  // Pick the settled stage of every chain and gate it with the enable.
  always_comb begin
    sync_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sync_out[i] = sync_q[i][SYNC_STG-1];
    end
    cond = sync_out & bus.en;
  end

  // Stability filter: count cycles of disagreement, accept on the
  // STABLE_CYC-th one, flag a glitch when agreement returns early.
  always_comb begin
    f_d    = f_q;
    cnt_d  = cnt_q;
    accept = '0;
    glitch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cond[i] == f_q[i]) begin
        cnt_d[i]  = '0;
        glitch[i] = (cnt_q[i] != '0);
      end else if (cnt_q[i] == CNT_LAST) begin
        f_d[i]    = cond[i];
        cnt_d[i]  = '0;
        accept[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Output encoding: pulses are derived from this cycle's accept events,
  // so a mode change alone never produces a pulse.
  always_comb begin
    flag_d = '0;
    case (mode)
      MODE_LEVEL: flag_d = f_d;
      MODE_RISE:  flag_d = accept & f_d;
      MODE_FALL:  flag_d = accept & ~f_d;
      MODE_ANY:   flag_d = accept;
      default:    flag_d = '0;
    endcase
  end

  // Glitch accounting: add this cycle's glitching channels, saturate,
  // and let a clear override anything counted in the same cycle.
  always_comb begin
    glitch_num = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      glitch_num = glitch_num + PC_W'(glitch[i]);
    end
    gsum = SUM_W'(gcnt_q) + SUM_W'(glitch_num);
    if (bus.glitch_clr) begin
      gcnt_d = '0;
    end else if (gsum > GSAT) begin
      gcnt_d = '1;
    end else begin
      gcnt_d = gsum[GCNT_W-1:0];
    end
  end

  // Register filter state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= '0;
      cnt_q  <= '0;
      flag_q <= '0;
      gcnt_q <= '0;
    end else begin
      f_q    <= f_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign bus.flag       = flag_q;
  assign bus.flag_any   = |flag_q;
  assign bus.glitch_cnt = gcnt_q;

endmodule

// File: doc/hazard_filter.md
HAZARD_FILTER -- requirements
Module: hazard_filter

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent channels; legal range 1..32.
REQ-002 Parameter SYNC_STG, default 2: synchroniser depth per channel; legal range 2..4.
REQ-003 Parameter STABLE_CYC, default 4: consecutive cycles a new condition value must hold before acceptance; legal range 1..255.
REQ-004 Parameter GCNT_W, default 8: glitch counter width.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 din  input  NUM_CH  raw per-channel data, asynchronous to clk.
REQ-008 en  input  NUM_CH  per-channel enable, synchronous to clk.
REQ-009 mode  input  2  global output mode: 00 level, 01 rise pulse, 10 fall pulse, 11 any-edge pulse.
REQ-010 glitch_clr  input  1  synchronous clear of glitch_cnt.
REQ-011 flag  output  NUM_CH  registered per-channel result.
REQ-012 flag_any  output  1  OR of all flag bits.
REQ-013 glitch_cnt  output  GCNT_W  saturating count of rejected glitches, all channels combined.

Function
REQ-014 Each din bit passes through SYNC_STG flops; the last stage is s[i].
REQ-015 Channel condition c[i] = s[i] AND en[i]; this is the only combinational term ahead of the filter.
REQ-016 Each channel holds an accepted value f[i] and a stability counter cnt[i] of width clog2(STABLE_CYC+1).
REQ-017 When c[i] equals f[i], cnt[i] <= 0 and f[i] holds.
REQ-018 When c[i] differs from f[i] and cnt[i] < STABLE_CYC-1, cnt[i] increments.
REQ-019 When c[i] differs from f[i] and cnt[i] = STABLE_CYC-1, f[i] <= c[i] and cnt[i] <= 0 (accept event).
REQ-020 A glitch is a cycle where c[i] equals f[i] while cnt[i] > 0; the change is discarded.
REQ-021 With STABLE_CYC=1, f[i] follows c[i] one cycle late and no glitch is ever counted.
REQ-022 In mode 00, flag[i] equals f[i].
REQ-023 In modes 01/10/11, flag[i] is high for exactly one cycle, registered on the same edge as an accept event of matching direction: 0->1 for 01, 1->0 for 10, either for 11. Otherwise flag[i] is 0.
REQ-024 Latency: din[i] changes before edge k and stays stable -> f[i] and flag[i] update at edge k+SYNC_STG+STABLE_CYC-1.
REQ-025 A mode change takes effect on the next edge. f and cnt are unaffected. No pulse is generated by the mode change itself.
REQ-026 glitch_cnt adds the number of channels glitching in that cycle and saturates at 2^GCNT_W-1 with no wrap.
REQ-027 glitch_clr has priority: glitch_cnt <= 0, and glitches occurring in the same cycle are not counted.
REQ-028 Deasserting en[i] forces c[i]=0, which is filtered like any other change. No immediate flag drop occurs.

Reset
REQ-029 On rst_n low, the following clear asynchronously to 0: synchroniser flops, f, cnt, flag, and glitch_cnt.
REQ-030 Reset mid-filter discards any pending change. After release, channels restart from f=0 with no pulse.
REQ-031 Release of rst_n is synchronous to clk externally. The block does not re-synchronise rst_n.

Verification (defaults NUM_CH=4, SYNC_STG=2, STABLE_CYC=4)
REQ-032 Scenario: mode=00, en=4'hF, din[0] 0->1 before edge 10 and held -> flag[0]=1 from edge 15 onward; flag_any=1.
REQ-033 Scenario: mode=00, din[1] high for 3 cycles then low -> flag[1] stays 0; glitch_cnt increments by 1.
REQ-034 Scenario: mode=11, din[2] rises then falls 20 cycles later -> two single-cycle flag[2] pulses, 20 cycles apart.
REQ-035 Scenario: 3 channels glitch in the same cycle, and glitch_cnt is at 254 -> glitch_cnt=255; a further glitch leaves it at 255; glitch_clr -> 0.
REQ-036 Scenario: din[3] held high, rst_n pulsed low while cnt[3]=2 -> all outputs 0 during reset; flag[3]=1 at edge SYNC_STG+STABLE_CYC-1 after release (mode 00).
REQ-037 Scenario: mode=01, f[0]=1, en[0] dropped and held low -> no pulse; mode=10 then shows one pulse 4 cycles after the drop, with STABLE_CYC delay only and no synchroniser delay.
